// File: rtl/frame_decode_if.sv
//------------------------------------------------------------------------------
// Module  : frame_decode_if
// Brief   : Decoded-bit input stream and assembled-byte output stream of frame_decode.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface frame_decode_if;
    logic       in_soc;
    logic       in_eoc;
    logic       in_data;
    logic       in_data_valid;
    logic       in_error;
    logic       out_soc;
    logic       out_eoc;
    logic [7:0] out_data;
    logic [2:0] out_data_bits;
    logic       out_data_valid;
    logic       out_error;

    modport master (
        output in_soc, in_eoc, in_data, in_data_valid, in_error,
        input  out_soc, out_eoc, out_data, out_data_bits, out_data_valid, out_error
    );

    modport slave (
        input  in_soc, in_eoc, in_data, in_data_valid, in_error,
        output out_soc, out_eoc, out_data, out_data_bits, out_data_valid, out_error
    );
endinterface

`default_nettype wire

// File: rtl/frame_decode.sv
//------------------------------------------------------------------------------
// Module  : frame_decode
// Brief   : Assembles LSB-first bytes from the ISO14443A decoded bit stream,
//           checks odd parity and passes a trailing partial byte with its bit count.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module frame_decode #(
    parameter bit CHECK_PARITY = 1'b1
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    frame_decode_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic [7:0] r_shift;
    logic [7:0] w_shift_nxt;
    logic       r_soc,   w_soc_nxt;
    logic       r_eoc,   w_eoc_nxt;
    logic       r_valid, w_valid_nxt;
    logic       r_err,   w_err_nxt;
    logic [7:0] r_data,  w_data_nxt;
    logic [2:0] r_bits,  w_bits_nxt;
    logic       w_parity_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_shift <= 8'd0;
            r_soc   <= 1'b0;
            r_eoc   <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_data  <= 8'd0;
            r_bits  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_soc   <= w_soc_nxt;
            r_eoc   <= w_eoc_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
            r_data  <= w_data_nxt;
            r_bits  <= w_bits_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_soc_nxt   = 1'b0;
        w_eoc_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        w_data_nxt  = r_data;
        w_bits_nxt  = r_bits;
        // Odd parity: the eight data bits plus the parity bit carry an odd number of ones.
        w_parity_ok = ^{r_shift, bus.in_data};

        if (bus.in_soc) begin
            // A start in any state (including a missing eoc) restarts the frame.
            w_soc_nxt   = 1'b1;
            w_cnt_nxt   = 4'd0;
            w_shift_nxt = 8'd0;
            w_state_nxt = ST_DATA;
        end else if (r_state != ST_IDLE) begin
            if (bus.in_eoc) begin
                w_eoc_nxt   = 1'b1;
                w_state_nxt = ST_IDLE;
                case (r_state)
                    ST_DATA: begin
                        if (r_cnt != 4'd0) begin
                            w_valid_nxt = 1'b1;
                            w_data_nxt  = r_shift;
                            w_bits_nxt  = r_cnt[2:0];
                        end
                    end
                    ST_PARITY: w_err_nxt = 1'b1;
                    default: ;
                endcase
            end else if (bus.in_error && (r_state != ST_ERROR)) begin
                w_err_nxt   = 1'b1;
                w_state_nxt = ST_ERROR;
            end else if (bus.in_data_valid) begin
                case (r_state)
                    ST_DATA: begin
                        w_shift_nxt[r_cnt[2:0]] = bus.in_data;
                        w_cnt_nxt               = r_cnt + 4'd1;
                        if (r_cnt == 4'd7)
                            w_state_nxt = ST_PARITY;
                    end
                    ST_PARITY: begin
                        if (CHECK_PARITY && !w_parity_ok) begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = ST_ERROR;
                        end else begin
                            w_valid_nxt = 1'b1;
                            w_data_nxt  = r_shift;
                            w_bits_nxt  = 3'd0;
                            w_cnt_nxt   = 4'd0;
                            w_shift_nxt = 8'd0;
                            w_state_nxt = ST_DATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.out_soc        = r_soc;
    assign bus.out_eoc        = r_eoc;
    assign bus.out_data       = r_data;
    assign bus.out_data_bits  = r_bits;
    assign bus.out_data_valid = r_valid;
    assign bus.out_error      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_frame_decode.sv
//------------------------------------------------------------------------------
// Module  : tb_frame_decode
// Brief   : Directed bench for frame_decode; parity-checking and non-checking
//           instances receive the same stimulus.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_frame_decode;

    logic clk;
    logic rst_n;
    logic soc, eoc, din, dv, err;
    int   n_checks;
    int   n_fail;

    frame_decode_if bus_p ();
    frame_decode_if bus_n ();

    assign bus_p.in_soc = soc;  assign bus_n.in_soc = soc;
    assign bus_p.in_eoc = eoc;  assign bus_n.in_eoc = eoc;
    assign bus_p.in_data = din; assign bus_n.in_data = din;
    assign bus_p.in_data_valid = dv; assign bus_n.in_data_valid = dv;
    assign bus_p.in_error = err; assign bus_n.in_error = err;

    frame_decode #(.CHECK_PARITY(1'b1)) u_dut_p (.clk(clk), .rst_n(rst_n), .bus(bus_p.slave));
    frame_decode #(.CHECK_PARITY(1'b0)) u_dut_n (.clk(clk), .rst_n(rst_n), .bus(bus_n.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst_n)
            assert ($onehot0({soc, eoc, dv})) else $error("soc/eoc/data_valid overlap");

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // One input event for one cycle; outputs are checked just after the edge
    // that registers them. flags = {soc, eoc, data_valid, error}.
    task automatic ev(input logic [4:0] in_v, input logic [3:0] exp_f,
                      input logic [7:0] exp_d, input logic [2:0] exp_b,
                      input bit both, input string tag);
        {soc, eoc, dv, din, err} = in_v;
        @(posedge clk);
        #1;
        {soc, eoc, dv, din, err} = 5'b0;
        check({tag, " flags"}, {bus_p.out_soc, bus_p.out_eoc, bus_p.out_data_valid, bus_p.out_error}, exp_f);
        if (exp_f[1]) begin
            check({tag, " data"}, bus_p.out_data, exp_d);
            check({tag, " bits"}, bus_p.out_data_bits, exp_b);
        end
        if (both) begin
            check({tag, " flags(np)"}, {bus_n.out_soc, bus_n.out_eoc, bus_n.out_data_valid, bus_n.out_error}, exp_f);
            if (exp_f[1])
                check({tag, " data(np)"}, bus_n.out_data, exp_d);
        end
    endtask

    task automatic sbit(input logic b, input string tag);
        ev({3'b001, b, 1'b0}, 4'b0000, 8'h00, 3'd0, 1'b1, tag);
    endtask

    task automatic sbits(input logic [7:0] v, input int n, input string tag);
        for (int i = 0; i < n; i++) sbit(v[i], tag);
    endtask

    task automatic ssoc(input string tag);
        ev(5'b10000, 4'b1000, 8'h00, 3'd0, 1'b1, tag);
    endtask

    // Full byte followed by its correct odd parity bit.
    task automatic sbyte(input logic [7:0] v, input string tag);
        sbits(v, 8, tag);
        ev({3'b001, ~^v, 1'b0}, 4'b0010, v, 3'd0, 1'b1, tag);
    endtask

    initial begin
        logic [7:0] rb;
        int nb;
        int tl;
        n_checks = 0;
        n_fail   = 0;
        {soc, eoc, dv, din, err} = 5'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset flags", {bus_p.out_soc, bus_p.out_eoc, bus_p.out_data_valid, bus_p.out_error}, 4'b0000);
        check("reset data", {bus_p.out_data, 5'd0, bus_p.out_data_bits}, 16'h0000);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // REQA short frame: 7 bits 0x26
        ssoc("reqa soc");
        sbits(8'h26, 7, "reqa bit");
        ev(5'b01000, 4'b0110, 8'h26, 3'd7, 1'b1, "reqa eoc");

        // Full byte 0x93 with correct parity
        ssoc("b93 soc");
        sbyte(8'h93, "b93");
        ev(5'b01000, 4'b0100, 8'h00, 3'd0, 1'b1, "b93 eoc");

        // 0x93 with wrong parity: error with checking, data without
        ssoc("bad par soc");
        sbits(8'h93, 8, "bad par bit");
        ev(5'b00100, 4'b0001, 8'h00, 3'd0, 1'b0, "bad par");
        check("bad par np flags", {bus_n.out_soc, bus_n.out_eoc, bus_n.out_data_valid, bus_n.out_error}, 4'b0010);
        check("bad par np data", {bus_n.out_data, 5'd0, bus_n.out_data_bits}, {8'h93, 8'h00});
        sbit(1'b1, "bad par ignored");
        ev(5'b01000, 4'b0100, 8'h00, 3'd0, 1'b0, "bad par eoc");

        // Two bytes plus 3-bit tail 0b101, one idle cycle inside the frame
        ssoc("multi soc");
        sbyte(8'h93, "multi b0");
        @(posedge clk);
        #1;
        sbyte(8'h20, "multi b1");
        sbits(8'h05, 3, "multi tail");
        ev(5'b01000, 4'b0110, 8'h05, 3'd3, 1'b1, "multi eoc");

        // Sequence error after 4 bits
        ssoc("serr soc");
        sbits(8'h0F, 4, "serr bit");
        ev(5'b00001, 4'b0001, 8'h00, 3'd0, 1'b1, "serr err");
        sbits(8'hFF, 4, "serr ignored");
        ev(5'b00001, 4'b0000, 8'h00, 3'd0, 1'b1, "serr err again");
        ev(5'b01000, 4'b0100, 8'h00, 3'd0, 1'b1, "serr eoc");

        // Eight bits then eoc: missing parity bit
        ssoc("nopar soc");
        sbits(8'h93, 8, "nopar bit");
        ev(5'b01000, 4'b0101, 8'h00, 3'd0, 1'b1, "nopar eoc");

        // Restart on soc without eoc
        ssoc("restart soc");
        sbits(8'h1F, 5, "restart bit");
        ssoc("restart soc2");
        sbits(8'h26, 7, "restart reqa");
        ev(5'b01000, 4'b0110, 8'h26, 3'd7, 1'b1, "restart eoc");

        // Asynchronous reset mid-byte
        ssoc("arst soc");
        sbits(8'h07, 3, "arst bit");
        ssoc("arst soc2");
        rst_n = 1'b0;
        #1;
        check("arst flags", {bus_p.out_soc, bus_p.out_eoc, bus_p.out_data_valid, bus_p.out_error}, 4'b0000);
        check("arst data", bus_p.out_data, 8'h00);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        sbits(8'h07, 3, "arst idle bit");
        ev(5'b01000, 4'b0000, 8'h00, 3'd0, 1'b1, "arst idle eoc");
        ssoc("arst reqa soc");
        sbits(8'h26, 7, "arst reqa bit");
        ev(5'b01000, 4'b0110, 8'h26, 3'd7, 1'b1, "arst reqa eoc");

        // Random byte frames with optional partial tail
        for (int f = 0; f < 6; f++) begin
            ssoc("rnd soc");
            nb = $urandom_range(1, 3);
            for (int k = 0; k < nb; k++) begin
                rb = 8'($urandom);
                sbyte(rb, "rnd byte");
            end
            tl = $urandom_range(0, 7);
            rb = 8'($urandom) & 8'((1 << tl) - 1);
            sbits(rb, tl, "rnd tail");
            if (tl != 0)
                ev(5'b01000, 4'b0110, rb, 3'(tl), 1'b1, "rnd eoc");
            else
                ev(5'b01000, 4'b0100, 8'h00, 3'd0, 1'b1, "rnd eoc");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
